// File: rtl/inv_mix_column_iter.sv
// Iterative AES InvMixColumns: one column-wide inverse-mix unit processes the four columns
// of a latched state over four cycles, then holds the result until the consumer accepts it.
module inv_mix_column_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]   fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] state_q, state_d;
    logic [127:0] out_q, out_d;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9, b, d, e built from the x2/x4/x8 doubling chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[31-8*i -: 8];
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        col_in = 32'h0;
        case (col_q)
            2'd0:    col_in = state_q[127:96];
            2'd1:    col_in = state_q[95:64];
            2'd2:    col_in = state_q[63:32];
            default: col_in = state_q[31:0];
        endcase
    end

    assign col_out = inv_mix_col(col_in);

    always_comb begin
        fsm_d   = fsm_q;
        col_d   = col_q;
        state_d = state_q;
        out_d   = out_q;
        case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = in_data;
                    col_d   = 2'd0;
                    fsm_d   = StBusy;
                end
            end
            StBusy: begin
                case (col_q)
                    2'd0:    out_d[127:96] = col_out;
                    2'd1:    out_d[95:64]  = col_out;
                    2'd2:    out_d[63:32]  = col_out;
                    default: out_d[31:0]   = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            col_q   <= 2'd0;
            state_q <= 128'h0;
            out_q   <= 128'h0;
        end else begin
            fsm_q   <= fsm_d;
            col_q   <= col_d;
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (fsm_q == StIdle);
    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q != StIdle);
    assign out_data  = out_q;

endmodule

// File: tb/tb_inv_mix_column_iter.sv
// Directed and round-trip bench for inv_mix_column_iter; outputs sampled on the falling edge.
module tb_inv_mix_column_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] FipsIn  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] FipsOut = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FixIn   = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;
    localparam logic [127:0] FixOut  = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;

    inv_mix_column_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns, used only to build round-trip stimulus.
    function automatic logic [127:0] fwd_mix(input logic [127:0] st);
        logic [127:0] r;
        logic [7:0] s0, s1, s2, s3;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            s0 = st[127-32*c -: 8];
            s1 = st[119-32*c -: 8];
            s2 = st[111-32*c -: 8];
            s3 = st[103-32*c -: 8];
            r[127-32*c -: 8] = xt(s0) ^ (xt(s1) ^ s1) ^ s2 ^ s3;
            r[119-32*c -: 8] = s0 ^ xt(s1) ^ (xt(s2) ^ s2) ^ s3;
            r[111-32*c -: 8] = s0 ^ s1 ^ xt(s2) ^ (xt(s3) ^ s3);
            r[103-32*c -: 8] = (xt(s0) ^ s0) ^ s1 ^ s2 ^ xt(s3);
        end
        return r;
    endfunction

    // Accept din at edge T, confirm out_valid low through T+3 and the result after T+4.
    task automatic send(input logic [127:0] din, input logic [127:0] exp, input bit noisy);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_accept", {127'h0, in_ready}, 128'h1);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("busy_no_valid", {126'h0, out_valid, in_ready}, 128'h0);
            if (noisy) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("done_flags", {125'h0, out_valid, in_ready, busy}, 128'h5);
        check_eq("result", out_data, exp);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("after_handshake", {125'h0, in_ready, out_valid, busy}, 128'h4);
    endtask

    initial begin
        logic [127:0] orig;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 128'h0;
        out_ready = 1'b0;
        #12;
        check_eq("reset_flags", {125'h0, in_ready, out_valid, busy}, 128'h4);
        check_eq("reset_data", out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        send(FipsIn, FipsOut, 1'b0);
        handshake();
        send(FixIn, FixOut, 1'b0);
        handshake();

        // Backpressure: result must hold for 10 cycles with out_ready low.
        send(FipsIn, FipsOut, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_flags", {126'h0, out_valid, in_ready}, 128'h2);
            check_eq("bp_data", out_data, FipsOut);
        end
        handshake();

        // Noise on in_valid/in_data while busy must not disturb the accepted state.
        send(FixIn, FixOut, 1'b1);
        in_valid = 1'b1;
        in_data  = FipsIn;
        @(negedge clk);
        check_eq("no_reaccept_done", {126'h0, out_valid, in_ready}, 128'h2);
        in_valid = 1'b0;
        handshake();

        // Reset after the second busy edge abandons the block.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = FipsIn;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_flags", {125'h0, in_ready, out_valid, busy}, 128'h4);
        check_eq("midrst_data", out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(FixIn, FixOut, 1'b0);
        handshake();

        for (int n = 0; n < 1000; n++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            send(fwd_mix(orig), orig, 1'b0);
            handshake();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
